dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Data-memory responder for the MEM stage; owns the handshake toward a multi-cycle backing data memory.
- Generates the `dataMem_stall` and `done_mem` signals and the read data consumed by the MEM/WB pipeline register.
- Freezes the pipeline while an access is outstanding.
- Sits between MEM-stage control (`mem_read`/`mem_write`) and the backing memory's valid/ready request plus response-valid interface.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, byte address width
- TIMEOUT, 64, cycles allowed in REQ+WAIT before the watchdog error fires; legal range 2..255

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  MEM-stage load request
- mem_write  in  1  MEM-stage store request
- addr_m  in  ADDR_W  access byte address
- wdata_m  in  DATA_W  store data
- dataMem_stall  out  1  freeze IF..MEM and MEM/WB register
- done_mem  out  1  one-cycle pulse: access complete, `read_data_m` valid
- read_data_m  out  DATA_W  load data (registered)
- err  out  1  sticky error (timeout, or misalignment when enabled)
- mem_req_valid  out  1  request to backing memory
- mem_req_ready  in  1  backing memory accepts request
- mem_req_wr  out  1  1 = write
- mem_req_addr  out  ADDR_W  latched address
- mem_req_wdata  out  DATA_W  latched store data
- mem_resp_valid  in  1  response/ack from backing memory
- mem_resp_rdata  in  DATA_W  read data

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE; `mem_req_valid` 0, `done_mem` 0, `err` 0, `read_data_m` 0, request latches 0, timer 0.
- Reset asserted mid-access abandons the transaction. Any later `mem_resp_valid` arriving in IDLE is ignored.
- State IDLE:
  - If `mem_read|mem_write`, latch address, write data and wr; `mem_req_wr` = `mem_write`.
  - `mem_write` has priority if both are high.
  - Go to REQ.
  - `dataMem_stall` = `mem_read|mem_write` combinationally in IDLE, so the requesting instruction freezes in its first cycle.
- State REQ:
  - `mem_req_valid`=1; address, data and wr stay stable until `mem_req_ready`.
  - On `mem_req_ready`, go to WAIT.
  - `dataMem_stall`=1.
- State WAIT:
  - `dataMem_stall`=1 until `mem_resp_valid`.
  - In the `mem_resp_valid` cycle: `dataMem_stall`=0 and `done_mem`=1 (both combinational), so the pipeline advances that edge.
  - For reads, `read_data_m` loads `mem_resp_rdata` at that edge and holds until the next completed read.
  - Next state IDLE.
- Response timing:
  - `mem_resp_valid` in the same cycle as `mem_req_ready` is not legal; the backing memory's minimum latency is 1 cycle.
  - `mem_resp_valid` in REQ or IDLE is ignored.
- Back-to-back accesses: a new request seen in IDLE the cycle after completion starts immediately. There are no bubble cycles beyond the backing latency.
- Timer (8-bit):
  - Clears on IDLE→REQ; increments each REQ/WAIT cycle.
  - Reaching TIMEOUT: set `err`, force completion (`done_mem`=1, `dataMem_stall`=0, `read_data_m`=0 for reads), go to IDLE.
- `err` is sticky until `rst`.
- Writes never modify `read_data_m`.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request in IDLE with `addr_m[0]`=1 issues no backing-memory request.
  - Sets `err` and completes in one cycle: `dataMem_stall`=0, `done_mem`=1 in that cycle, read data 0, stays IDLE.
- Undefined: address bit 0 is passed through unchanged and no check is made.

Decomposition:
- Shared package (`dmem_pkg`):
  - state enum (IDLE, REQ, WAIT)
  - default DATA_W/ADDR_W/TIMEOUT constants
  - timer width constant
- One natural sub-module: `dmem_timeout_ctr` (clear/enable counter with terminal-count flag). The FSM stays in the top.

Test Plan:
- Read from 0x0010, ready after 2 cycles, resp 3 cycles later with 0xBEEF:
  - stall high 6 cycles;
  - done_mem pulse with stall low in the resp cycle;
  - `read_data_m`=0xBEEF next cycle and held.
- Write 0x1234 to 0x0020:
  - `mem_req_addr`/`mem_req_wdata` stable while ready is low;
  - done_mem on ack;
  - `read_data_m` unchanged from the prior 0xBEEF.
- Back-to-back read 0x0002 then read 0x0004:
  - second `mem_req_valid` rises the cycle after the first done_mem;
  - both data values returned in order.
- No response for 64 cycles:
  - `err`=1, done_mem pulse, stall drops, state IDLE;
  - `err` stays 1 across later good accesses until `rst`.
- `rst` pulsed during WAIT, followed by a stray `mem_resp_valid` in IDLE:
  - all outputs at reset values;
  - no done_mem.
- With DMEM_ALIGN_CHECK_EN, read 0x0003:
  - no `mem_req_valid`; `err`=1;
  - done_mem same cycle; zero stall cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory access controller
//
// Purpose : FSM state encoding, default geometry and watchdog timer width used by
//           dmem_access_ctrl and dmem_timeout_ctr.
// Ports   : none (package).
// Config  : none here; DMEM_ALIGN_CHECK_EN is consumed by dmem_access_ctrl.

package dmem_pkg;

    localparam int DMEM_DATA_W  = 16;
    localparam int DMEM_ADDR_W  = 16;
    localparam int DMEM_TIMEOUT = 64;

    // Watchdog counter width; TIMEOUT must fit (legal range 2..255).
    localparam int DMEM_TMR_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// rtl/dmem_timeout_ctr.sv - clear/enable watchdog counter with terminal-count flag
//
// Purpose : counts cycles an access spends outstanding; tc_o flags the cycle in
//           which the count equals TIMEOUT-1, i.e. the TIMEOUT-th outstanding cycle.
// Ports   : clk, rst    - clock, synchronous active-high reset
//           clr_i       - load zero (priority over en_i)
//           en_i        - increment by one
//           tc_o        - terminal count reached (combinational from the count)

module dmem_timeout_ctr
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [DMEM_TMR_W-1:0] TC_VAL = DMEM_TMR_W'(TIMEOUT - 1);

    logic [DMEM_TMR_W-1:0] count_q;
    logic [DMEM_TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + DMEM_TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory responder with stall/done handshake
//
// Purpose : accepts a load/store from the MEM stage, issues one valid/ready request
//           to a multi-cycle backing memory, freezes the pipeline until the response
//           (or the watchdog) completes the access, and returns registered load data.
// Ports   : clk, rst                         - clock, synchronous active-high reset
//           mem_read, mem_write              - MEM-stage access request (write wins)
//           addr_m, wdata_m                  - access address / store data
//           dataMem_stall                    - freeze IF..MEM and MEM/WB
//           done_mem                         - one-cycle completion pulse
//           read_data_m                      - registered load data
//           err                              - sticky error flag
//           mem_req_valid/ready/wr/addr/wdata - request channel to backing memory
//           mem_resp_valid, mem_resp_rdata   - response channel from backing memory
// Config  : DMEM_ALIGN_CHECK_EN - when defined, odd addresses are rejected in IDLE
//           with err set and a same-cycle completion; no backing request is issued.

module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] wdata_m,
    output logic              dataMem_stall,
    output logic              done_mem,
    output logic [DATA_W-1:0] read_data_m,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    dmem_state_e       state_q;
    dmem_state_e       state_d;

    logic              req_wr_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              access;
    logic              misalign;
    logic              latch_en;
    logic              rd_load;
    logic              rd_zero;
    logic              err_set;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_tc;

    assign access = mem_read | mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = addr_m[0];
`else
    assign misalign = 1'b0;
`endif

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Stall and done are combinational so the pipeline freezes in the first cycle
    // of an access and advances on the very edge the response arrives.
    always_comb begin
        state_d       = state_q;
        dataMem_stall = 1'b0;
        done_mem      = 1'b0;
        mem_req_valid = 1'b0;
        latch_en      = 1'b0;
        rd_load       = 1'b0;
        rd_zero       = 1'b0;
        err_set       = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misalign) begin
                        // Rejected without touching the backing memory.
                        done_mem = 1'b1;
                        err_set  = 1'b1;
                        rd_zero  = ~mem_write;
                    end else begin
                        dataMem_stall = 1'b1;
                        latch_en      = 1'b1;
                        tmr_clr       = 1'b1;
                        state_d       = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                mem_req_valid = 1'b1;
                tmr_en        = 1'b1;
                if (tmr_tc) begin
                    // Watchdog wins over a coincident ready: the request is abandoned.
                    done_mem = 1'b1;
                    err_set  = 1'b1;
                    rd_zero  = ~req_wr_q;
                    state_d  = ST_IDLE;
                end else begin
                    dataMem_stall = 1'b1;
                    if (mem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                tmr_en = 1'b1;
                if (mem_resp_valid) begin
                    // A genuine response in the last allowed cycle still counts as good.
                    done_mem = 1'b1;
                    rd_load  = ~req_wr_q;
                    state_d  = ST_IDLE;
                end else if (tmr_tc) begin
                    done_mem = 1'b1;
                    err_set  = 1'b1;
                    rd_zero  = ~req_wr_q;
                    state_d  = ST_IDLE;
                end else begin
                    dataMem_stall = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                req_wr_q    <= mem_write;
                req_addr_q  <= addr_m;
                req_wdata_q <= wdata_m;
            end
            if (rd_load) begin
                rdata_q <= mem_resp_rdata;
            end else if (rd_zero) begin
                rdata_q <= '0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_req_wr    = req_wr_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign read_data_m   = rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl

module tb_dmem_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] wdata_m;
    logic          dataMem_stall;
    logic          done_mem;
    logic [DW-1:0] read_data_m;
    logic          err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_wr;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_rdata;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .addr_m         (addr_m),
        .wdata_m        (wdata_m),
        .dataMem_stall  (dataMem_stall),
        .done_mem       (done_mem),
        .read_data_m    (read_data_m),
        .err            (err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wr     (mem_req_wr),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: is an access outstanding, has the memory taken
    // it, how many cycles has it been outstanding, and what was captured.
    bit          m_busy;
    bit          m_acc;
    bit          m_wr;
    int          m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd;
    bit          m_err;

    int stall_cnt;
    int done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_wr = 0; m_age = 0;
        m_addr = '0; m_wdata = '0; m_rd = '0; m_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_read = 0; mem_write = 0; addr_m = '0; wdata_m = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit rdy, input bit rsp,
                         input logic [DW-1:0] rdat);
        bit e_stall, e_done, e_valid, tmo, req, mis;
        mem_read = rd; mem_write = wr; addr_m = a; wdata_m = wd;
        mem_req_ready = rdy; mem_resp_valid = rsp; mem_resp_rdata = rdat;
        @(negedge clk);
        req = rd | wr;
        mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = a[0];
`endif
        tmo     = m_busy && (m_age == TO - 1);
        e_valid = m_busy && !m_acc;
        if (!m_busy) begin
            e_stall = req && !mis;
            e_done  = req && mis;
        end else if ((m_acc && rsp) || tmo) begin
            e_stall = 0;
            e_done  = 1;
        end else begin
            e_stall = 1;
            e_done  = 0;
        end
        chk("stall", dataMem_stall, e_stall);
        chk("done", done_mem, e_done);
        chk("req_valid", mem_req_valid, e_valid);
        chk("req_wr", mem_req_wr, m_wr);
        chk("req_addr", mem_req_addr, m_addr);
        chk("req_wdata", mem_req_wdata, m_wdata);
        chk("read_data", read_data_m, m_rd);
        chk("err", err, m_err);
        stall_cnt += int'(dataMem_stall);
        done_cnt  += int'(done_mem);
        @(posedge clk);
        if (!m_busy) begin
            if (req && mis) begin
                m_err = 1;
                if (!wr) m_rd = '0;
            end else if (req) begin
                m_busy = 1; m_acc = 0; m_age = 0;
                m_wr = wr; m_addr = a; m_wdata = wd;
            end
        end else if (m_acc && rsp) begin
            if (!m_wr) m_rd = rdat;
            m_busy = 0;
        end else if (tmo) begin
            m_err = 1;
            if (!m_wr) m_rd = '0;
            m_busy = 0;
        end else begin
            if (!m_acc && rdy) m_acc = 1;
            m_age++;
        end
        #1;
    endtask

    initial begin
        int n;
        bit rd_h, wr_h, rdy, rsp;
        int rdy_wait, rsp_wait;
        logic [AW-1:0] a_h;
        logic [DW-1:0] wd_h;

        do_reset();
        chk("rst_stall", dataMem_stall, 0);
        chk("rst_done", done_mem, 0);
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_rdata", read_data_m, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_req_addr, 0);

        // Read 0x0010: ready on the third REQ cycle, response three cycles later.
        stall_cnt = 0; done_cnt = 0;
        cycle(1, 0, 16'h0010, 0, 0, 0, 0);
        cycle(1, 0, 16'h0010, 0, 0, 0, 0);
        cycle(1, 0, 16'h0010, 0, 0, 0, 0);
        cycle(1, 0, 16'h0010, 0, 1, 0, 0);
        cycle(1, 0, 16'h0010, 0, 0, 0, 0);
        cycle(1, 0, 16'h0010, 0, 0, 0, 0);
        cycle(1, 0, 16'h0010, 0, 0, 1, 16'hBEEF);
        chk("rd_stall_cycles", stall_cnt, 6);
        chk("rd_done_count", done_cnt, 1);
        chk("rd_data_beef", read_data_m, 16'hBEEF);

        // Write 0x1234 to 0x0020 with the pipeline inputs wandering while ready is low.
        done_cnt = 0;
        cycle(0, 1, 16'h0020, 16'h1234, 0, 0, 0);
        cycle(0, 1, 16'hFFFF, 16'hAAAA, 0, 0, 0);
        cycle(0, 1, 16'h5555, 16'h0F0F, 0, 0, 0);
        chk("wr_addr_held", mem_req_addr, 16'h0020);
        chk("wr_data_held", mem_req_wdata, 16'h1234);
        cycle(0, 1, 16'h0020, 16'h1234, 1, 0, 0);
        cycle(0, 1, 16'h0020, 16'h1234, 0, 1, 16'hCAFE);
        chk("wr_done_count", done_cnt, 1);
        chk("wr_keeps_rdata", read_data_m, 16'hBEEF);

        // Back-to-back reads 0x0002 then 0x0004.
        cycle(1, 0, 16'h0002, 0, 0, 0, 0);
        cycle(1, 0, 16'h0002, 0, 1, 0, 0);
        cycle(1, 0, 16'h0002, 0, 0, 1, 16'h1111);
        cycle(1, 0, 16'h0004, 0, 0, 0, 0);
        chk("b2b_valid", mem_req_valid, 1);
        chk("b2b_first", read_data_m, 16'h1111);
        cycle(1, 0, 16'h0004, 0, 1, 0, 0);
        cycle(1, 0, 16'h0004, 0, 0, 1, 16'h2222);
        chk("b2b_second", read_data_m, 16'h2222);

        // Watchdog: accepted read that never answers.
        cycle(1, 0, 16'h0008, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < TO + 16 && m_busy; i++) begin
            cycle(1, 0, 16'h0008, 0, (i == 0), 0, 0);
            n++;
        end
        chk("tmo_cycles", n, TO);
        chk("tmo_err", err, 1);
        chk("tmo_rdata_zero", read_data_m, 0);
        cycle(1, 0, 16'h000A, 0, 0, 0, 0);
        cycle(1, 0, 16'h000A, 0, 1, 0, 0);
        cycle(1, 0, 16'h000A, 0, 0, 1, 16'h3333);
        chk("err_sticky", err, 1);
        chk("after_tmo_read", read_data_m, 16'h3333);

        // Reset in WAIT, then a stray response while idle.
        cycle(1, 0, 16'h000C, 0, 0, 0, 0);
        cycle(1, 0, 16'h000C, 0, 1, 0, 0);
        cycle(1, 0, 16'h000C, 0, 0, 0, 0);
        do_reset();
        done_cnt = 0;
        cycle(0, 0, 16'h0000, 0, 0, 1, 16'hDEAD);
        chk("stray_no_done", done_cnt, 0);
        chk("stray_rdata", read_data_m, 0);
        chk("stray_err", err, 0);
        chk("stray_valid", mem_req_valid, 0);

`ifdef DMEM_ALIGN_CHECK_EN
        stall_cnt = 0; done_cnt = 0;
        cycle(1, 0, 16'h0003, 0, 0, 0, 0);
        chk("align_stall", stall_cnt, 0);
        chk("align_done", done_cnt, 1);
        chk("align_err", err, 1);
        chk("align_no_req", mem_req_valid, 0);
        do_reset();
`endif

        // Randomized traffic against the model.
        rd_h = 0; wr_h = 0; a_h = '0; wd_h = '0;
        rdy_wait = 0; rsp_wait = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            rdy = 0;
            rsp = 0;
            if (!m_busy) begin
                case ($urandom_range(0, 3))
                    0: begin rd_h = 0; wr_h = 0; end
                    1: begin rd_h = 1; wr_h = 0; end
                    2: begin rd_h = 0; wr_h = 1; end
                    default: begin rd_h = 1; wr_h = 1; end
                endcase
                a_h  = AW'($urandom);
                wd_h = DW'($urandom);
                rdy_wait = ($urandom_range(0, 19) == 0) ? 200 : $urandom_range(0, 3);
                rsp_wait = ($urandom_range(0, 19) == 0) ? 200 : $urandom_range(1, 5);
                rsp = ($urandom_range(0, 7) == 0);
                cycle(rd_h, wr_h, a_h, wd_h, 0, rsp, DW'($urandom));
            end else begin
                if (!m_acc) begin
                    rdy = (rdy_wait == 0);
                    if (!rdy) rdy_wait--;
                    rsp = !rdy && ($urandom_range(0, 7) == 0);
                end else begin
                    rsp = (rsp_wait <= 1);
                    rsp_wait--;
                end
                cycle(rd_h, wr_h, AW'($urandom), DW'($urandom), rdy, rsp, DW'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
